// File: rtl/led_counter_pkg.sv
// Shared opcode and state encodings for the LED counter sequencer.
package led_counter_pkg;

    localparam logic [1:0] OP_START_UP   = 2'd0;
    localparam logic [1:0] OP_START_DOWN = 2'd1;
    localparam logic [1:0] OP_STOP       = 2'd2;
    localparam logic [1:0] OP_LOAD       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider: tick is high on the last cycle of each
// PRESCALE-cycle period while enabled; clear restarts the period.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [31:0] TERM = 32'(PRESCALE - 1);

    logic [31:0] pc_q, pc_d;

    assign tick = enable && (pc_q == TERM);

    always_comb begin
        pc_d = pc_q;
        if (clear) begin
            pc_d = '0;
        end else if (enable) begin
            pc_d = tick ? '0 : pc_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/led_counter_sequencer.sv
// Command-driven up/down LED counter: valid/ready command port, FSM,
// prescaled stepping and a registered wrap pulse.
module led_counter_sequencer
    import led_counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] led,
    output logic             running,
    output logic             wrap
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             wrap_q, wrap_d;
    logic             ready_q, ready_d;
    logic             running_q, running_d;
    logic             accept;
    logic             tick;

    assign accept = cmd_valid && ready_q;

    // Every accepted command restarts the step period.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (state_q != ST_IDLE),
        .clear   (accept),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        wrap_d  = 1'b0;
        ready_d = !accept;
        if (accept) begin
            // A command on a terminal-count edge discards that step.
            case (cmd_op)
                OP_START_UP:   state_d = ST_UP;
                OP_START_DOWN: state_d = ST_DOWN;
                OP_STOP:       state_d = ST_IDLE;
                OP_LOAD:       led_d   = cmd_data;
                default:       ;
            endcase
        end else if (tick) begin
            if (state_q == ST_UP) begin
                led_d  = led_q + 1'b1;
                wrap_d = (led_q == {WIDTH{1'b1}});
            end else begin
                led_d  = led_q - 1'b1;
                wrap_d = (led_q == '0);
            end
        end
        running_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            led_q     <= '0;
            wrap_q    <= 1'b0;
            ready_q   <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            wrap_q    <= wrap_d;
            ready_q   <= ready_d;
            running_q <= running_d;
        end
    end

    assign cmd_ready = ready_q;
    assign led       = led_q;
    assign running   = running_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_led_counter_sequencer.sv
// Directed bench for led_counter_sequencer with PRESCALE=4, WIDTH=8.
module tb_led_counter_sequencer;

    logic       clock;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] led;
    logic       running;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    led_counter_sequencer #(
        .WIDTH    (8),
        .PRESCALE (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .led       (led),
        .running   (running),
        .wrap      (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to n rising edges later, then settle 1 time unit.
    task automatic tick_n(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present a command; returns 1 unit after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        int guard = 0;
        while (!cmd_ready && guard < 4) begin
            tick_n(1);
            guard++;
        end
        check("send_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick_n(1);
        cmd_valid = 1'b0;
    endtask

    localparam logic [1:0] UP = 2'd0, DN = 2'd1, STP = 2'd2, LD = 2'd3;

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        check("rst_led", 32'(led), 32'h0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 20; i++) begin
            tick_n(1);
            check("idle_led", 32'(led), 32'h0);
            check("idle_wrap", 32'(wrap), 32'd0);
            check("idle_running", 32'(running), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
        end

        // START_UP at edge 0; a command during the ready-low cycle is dropped
        send(UP, 8'h00);
        check("up_running_c1", 32'(running), 32'd1);
        check("up_ready_c1", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_op = LD; cmd_data = 8'h55;
        tick_n(1);
        cmd_valid = 1'b0;
        check("ignored_led", 32'(led), 32'h0);
        check("up_ready_c2", 32'(cmd_ready), 32'd1);
        tick_n(2);
        check("up_e3", 32'(led), 32'h0);
        tick_n(1);
        check("up_e4", 32'(led), 32'h1);
        tick_n(4);
        check("up_e8", 32'(led), 32'h2);
        tick_n(3);
        check("up_e11", 32'(led), 32'h2);
        tick_n(1);
        check("up_e12", 32'(led), 32'h3);

        // LOAD 0xFE, START_UP, wrap upward
        send(STP, 8'h00);
        check("stop_running", 32'(running), 32'd0);
        check("stop_led", 32'(led), 32'h3);
        send(LD, 8'hFE);
        check("load_fe", 32'(led), 32'hFE);
        check("load_idle", 32'(running), 32'd0);
        send(UP, 8'h00);
        tick_n(3);
        check("wu_e3", 32'(led), 32'hFE);
        tick_n(1);
        check("wu_e4", 32'(led), 32'hFF);
        check("wu_e4_wrap", 32'(wrap), 32'd0);
        tick_n(4);
        check("wu_e8", 32'(led), 32'h00);
        check("wu_e8_wrap", 32'(wrap), 32'd1);
        tick_n(1);
        check("wu_e9_wrap", 32'(wrap), 32'd0);
        tick_n(3);
        check("wu_e12", 32'(led), 32'h01);
        check("wu_e12_wrap", 32'(wrap), 32'd0);

        // START_DOWN from 0, STOP on the terminal-count edge
        send(STP, 8'h00);
        send(LD, 8'h00);
        send(DN, 8'h00);
        tick_n(4);
        check("dn_e4", 32'(led), 32'hFF);
        check("dn_e4_wrap", 32'(wrap), 32'd1);
        tick_n(1);
        check("dn_e5_wrap", 32'(wrap), 32'd0);
        tick_n(2);
        send(STP, 8'h00);
        check("dn_stop_led", 32'(led), 32'hFF);
        check("dn_stop_running", 32'(running), 32'd0);
        check("dn_stop_wrap", 32'(wrap), 32'd0);
        tick_n(6);
        check("dn_hold", 32'(led), 32'hFF);

        // LOAD 0x80 on a terminal-count edge while UP
        send(UP, 8'h00);
        tick_n(3);
        send(LD, 8'h80);
        check("ld80_led", 32'(led), 32'h80);
        check("ld80_wrap", 32'(wrap), 32'd0);
        check("ld80_running", 32'(running), 32'd1);
        tick_n(3);
        check("ld80_e7", 32'(led), 32'h80);
        tick_n(1);
        check("ld80_e8", 32'(led), 32'h81);

        // Async reset pulse mid-count with a command held across it
        send(STP, 8'h00);
        send(LD, 8'h37);
        send(UP, 8'h00);
        tick_n(2);
        check("pre_rst_led", 32'(led), 32'h37);
        cmd_valid = 1'b1; cmd_op = DN; cmd_data = 8'h00;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("arst_led", 32'(led), 32'h0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        check("arst_wrap", 32'(wrap), 32'd0);
        tick_n(1);
        check("arst_edge_running", 32'(running), 32'd0);
        check("arst_edge_led", 32'(led), 32'h0);
        reset_n = 1'b1;
        tick_n(1);
        cmd_valid = 1'b0;
        check("post_rst_running", 32'(running), 32'd1);
        check("post_rst_ready", 32'(cmd_ready), 32'd0);
        check("post_rst_led", 32'(led), 32'h0);
        tick_n(3);
        check("post_rst_e3", 32'(led), 32'h0);
        tick_n(1);
        check("post_rst_e4", 32'(led), 32'hFF);
        check("post_rst_e4_wrap", 32'(wrap), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
